pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Sits beside the IF/ID, ID/EX, EX/MEM, MEM/WB regs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_REDIR = 2'd1,
    CTRL_WAIT  = 2'd2
  } ctrl_state_e;

  localparam int WAIT_CNT_W = 16;
  localparam int BUB_CNT_W  = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_hazard_ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect bubbles, data-memory freeze.
// state      | meaning
// CTRL_RUN   | normal flow, load-use detection active
// CTRL_REDIR | emitting IF/ID bubbles while fetch catches up after a redirect
// CTRL_WAIT  | pipe frozen on data memory; ret_state remembers where to resume
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH       = 5,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ID_Rs1_Addr,
  input  logic [ADDR_WIDTH-1:0] ID_Rs2_Addr,
  input  logic                  ID_Rs1_Used,
  input  logic                  ID_Rs2_Used,
  input  logic                  EX_Mem_r,
  input  logic [ADDR_WIDTH-1:0] EX_Rd_Addr,
  input  logic                  EX_Redirect,
  input  logic                  MEM_Req,
  input  logic                  MEM_Ready,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Write,
  output logic                  ID_EX_Flush,
  output logic                  EX_MEM_Write,
  output logic                  MEM_WB_Flush,
  output logic                  Mem_Timeout,
  output logic [CNT_WIDTH-1:0]  Stall_Cnt,
  output logic [CNT_WIDTH-1:0]  Flush_Cnt,
  output logic [1:0]            Ctrl_State
);

  ctrl_state_e           state, ret_state, eff_state;
  ctrl_state_e           nxt_state, nxt_ret;
  logic [BUB_CNT_W-1:0]  bub_cnt, nxt_bub;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  mem_stall, load_use;

  assign mem_stall = MEM_Req & ~MEM_Ready;
  assign load_use  = EX_Mem_r && (EX_Rd_Addr != '0) &&
                     ((ID_Rs1_Used && (ID_Rs1_Addr == EX_Rd_Addr)) ||
                      (ID_Rs2_Used && (ID_Rs2_Addr == EX_Rd_Addr)));

  // The release cycle out of WAIT behaves exactly like the state that was frozen.
  assign eff_state = (state == CTRL_WAIT) ? ret_state : state;

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b1;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    nxt_state    = state;
    nxt_ret      = ret_state;
    nxt_bub      = bub_cnt;
    if (mem_stall) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
      nxt_state    = CTRL_WAIT;
      if (state != CTRL_WAIT) nxt_ret = state;
    end else if (EX_Redirect) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      if (REDIRECT_BUBBLES > 0) begin
        nxt_state = CTRL_REDIR;
        nxt_bub   = BUB_CNT_W'(REDIRECT_BUBBLES);
      end else begin
        nxt_state = CTRL_RUN;
      end
    end else if (eff_state == CTRL_REDIR) begin
      IF_ID_Flush = 1'b1;
      nxt_bub     = bub_cnt - BUB_CNT_W'(1);
      nxt_state   = (bub_cnt == BUB_CNT_W'(1)) ? CTRL_RUN : CTRL_REDIR;
    end else begin
      nxt_state = CTRL_RUN;
      if (load_use) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CTRL_RUN;
      ret_state   <= CTRL_RUN;
      bub_cnt     <= '0;
      wait_cnt    <= '0;
      Mem_Timeout <= 1'b0;
    end else begin
      state     <= nxt_state;
      ret_state <= nxt_ret;
      bub_cnt   <= nxt_bub;
      if (mem_stall) begin
        if (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT - 1)) Mem_Timeout <= 1'b1;
        if (wait_cnt != {WAIT_CNT_W{1'b1}}) wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign Ctrl_State = state;

  pipe_hazard_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~PC_Write),
    .cnt   (Stall_Cnt)
  );

  pipe_hazard_ctrl_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (IF_ID_Flush),
    .cnt   (Flush_Cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int AW  = 5;
  localparam int BUB = 2;
  localparam int TMO = 8;
  localparam int CW  = 32;

  localparam logic [6:0] CTL_NORM   = 7'b1101010;
  localparam logic [6:0] CTL_FREEZE = 7'b0000001;
  localparam logic [6:0] CTL_REDIR  = 7'b1111110;
  localparam logic [6:0] CTL_BUBBLE = 7'b1111010;
  localparam logic [6:0] CTL_LU     = 7'b0001110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] rs1 = '0, rs2 = '0, ex_rd = '0;
  logic rs1_used = 1'b0, rs2_used = 1'b0, ex_mem_r = 1'b0, redirect = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, tmo_flag;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0] ctrl_state;
  logic [6:0] ctl;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: outstanding redirect bubbles, whether last cycle was frozen, wait length.
  int     m_pend = 0;
  bit     m_frozen = 0;
  int     m_wait = 0;
  bit     m_tmo = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .ADDR_WIDTH(AW), .REDIRECT_BUBBLES(BUB), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Rs1_Addr(rs1), .ID_Rs2_Addr(rs2), .ID_Rs1_Used(rs1_used), .ID_Rs2_Used(rs2_used),
    .EX_Mem_r(ex_mem_r), .EX_Rd_Addr(ex_rd), .EX_Redirect(redirect),
    .MEM_Req(mem_req), .MEM_Ready(mem_ready),
    .PC_Write(pc_w), .IF_ID_Write(ifid_w), .IF_ID_Flush(ifid_f), .ID_EX_Write(idex_w),
    .ID_EX_Flush(idex_f), .EX_MEM_Write(exmem_w), .MEM_WB_Flush(memwb_f),
    .Mem_Timeout(tmo_flag), .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt), .Ctrl_State(ctrl_state)
  );

  assign ctl = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1 = '0; rs2 = '0; ex_rd = '0; rs1_used = 0; rs2_used = 0;
    ex_mem_r = 0; redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic model_reset();
    m_pend = 0; m_frozen = 0; m_wait = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
  endtask

  // Called at negedge with inputs applied: checks this cycle, advances model across posedge.
  task automatic step(input string tag);
    logic [6:0] exp_ctl;
    bit st, lu;
    int exp_state;
    st = mem_req && !mem_ready;
    lu = ex_mem_r && (ex_rd != 0) &&
         ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
    if (st)               exp_ctl = CTL_FREEZE;
    else if (redirect)    exp_ctl = CTL_REDIR;
    else if (m_pend > 0)  exp_ctl = CTL_BUBBLE;
    else if (lu)          exp_ctl = CTL_LU;
    else                  exp_ctl = CTL_NORM;
    exp_state = m_frozen ? 2 : (m_pend > 0 ? 1 : 0);
    #1;
    chk({tag, "_ctl"}, 64'(ctl), 64'(exp_ctl));
    chk({tag, "_state"}, 64'(ctrl_state), 64'(exp_state));
    chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
    chk({tag, "_timeout"}, 64'(tmo_flag), 64'(m_tmo));
    if (!exp_ctl[6]) m_stall++;
    if (exp_ctl[4])  m_flush++;
    if (st) begin
      m_wait++;
      if (m_wait == TMO) m_tmo = 1;
      m_frozen = 1;
    end else begin
      m_wait = 0;
      m_frozen = 0;
      if (redirect)        m_pend = BUB;
      else if (m_pend > 0) m_pend--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask

  initial begin
    do_reset();
    step("reset_idle");
    chk("reset_stall0", 64'(stall_cnt), 64'd0);

    // lw x5 in EX, add x6,x5,x7 in ID
    ex_mem_r = 1; ex_rd = 5; rs1 = 5; rs1_used = 1; rs2 = 7; rs2_used = 1;
    step("lu_x5");
    idle_inputs();
    step("lu_after");
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);

    ex_mem_r = 1; ex_rd = 0; rs1 = 0; rs1_used = 1;
    step("lu_x0");
    ex_mem_r = 1; ex_rd = 9; rs1 = 9; rs2 = 9; rs1_used = 1; rs2_used = 1;
    step("lu_both");
    idle_inputs();
    step("lu_both_after");
    chk("lu_both_once", 64'(stall_cnt), 64'd2);

    redirect = 1;
    step("redir_0");
    redirect = 0;
    step("redir_1");
    step("redir_2");
    step("redir_done");
    chk("redir_flush3", 64'(flush_cnt), 64'd3);

    // freeze while one redirect bubble is still owed
    redirect = 1;
    step("rw_redir");
    redirect = 0;
    step("rw_bub1");
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) step("rw_freeze");
    mem_ready = 1;
    step("rw_release");
    idle_inputs();
    step("rw_run");

    // load-use loses to a same-cycle redirect
    ex_mem_r = 1; ex_rd = 3; rs1 = 3; rs1_used = 1; redirect = 1;
    step("lu_vs_redir");
    idle_inputs();
    step("lvr_b1");
    step("lvr_b2");

    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 10; i++) step("tmo_wait");
    mem_ready = 1;
    step("tmo_release");
    idle_inputs();
    step("tmo_after");
    chk("tmo_sticky", 64'(tmo_flag), 64'd1);

    // asynchronous reset while frozen
    mem_req = 1; mem_ready = 0;
    step("ar_freeze");
    idle_inputs();
    rst_n = 0;
    #1;
    chk("ar_state", 64'(ctrl_state), 64'd0);
    chk("ar_ctl", 64'(ctl), 64'(CTL_NORM));
    chk("ar_tmo", 64'(tmo_flag), 64'd0);
    chk("ar_stall", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1;
    step("ar_after");

    for (int i = 0; i < 400; i++) begin
      rs1 = AW'($urandom_range(0, 3));
      rs2 = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      ex_mem_r = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 99) < 15);
      mem_req = ($urandom_range(0, 99) < 25);
      mem_ready = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
